// File: rtl/slave_port_sched_if.sv
// Two-master to one-slave port bundle for slave_port_sched.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface slave_port_sched_if;
  logic        master_0_req;
  logic        master_1_req;
  logic        master_0_cmd;
  logic        master_1_cmd;
  logic [31:0] master_0_addr;
  logic [31:0] master_1_addr;
  logic [31:0] master_0_wdata;
  logic [31:0] master_1_wdata;
  logic        master_0_ack;
  logic        master_1_ack;
  logic [31:0] master_0_rdata;
  logic [31:0] master_1_rdata;
  logic        slave_req;
  logic        slave_cmd;
  logic [31:0] slave_addr;
  logic [31:0] slave_wdata;
  logic        slave_ack;
  logic [31:0] slave_rdata;
  logic        slave_err;

  modport slave (
    input  master_0_req, master_1_req, master_0_cmd, master_1_cmd,
    input  master_0_addr, master_1_addr, master_0_wdata, master_1_wdata,
    output master_0_ack, master_1_ack, master_0_rdata, master_1_rdata,
    output slave_req, slave_cmd, slave_addr, slave_wdata, slave_err,
    input  slave_ack, slave_rdata
  );

  modport master (
    output master_0_req, master_1_req, master_0_cmd, master_1_cmd,
    output master_0_addr, master_1_addr, master_0_wdata, master_1_wdata,
    input  master_0_ack, master_1_ack, master_0_rdata, master_1_rdata,
    input  slave_req, slave_cmd, slave_addr, slave_wdata, slave_err,
    output slave_ack, slave_rdata
  );
endinterface

// File: rtl/slave_port_sched.sv
// Round-robin scheduler sharing one slave port between two masters.
// Optional REQ-phase timeout abort is compiled in with SLAVE_PORT_TIMEOUT_EN.
module slave_port_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  slave_port_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, RDATA} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        gnt;
  logic        gnt_nxt;
  logic        last_gnt;
  logic        last_gnt_nxt;

  logic        gnt_req;
  logic        gnt_cmd;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic        gnt_ack;
  logic [31:0] gnt_rdata;
  logic        err;
  logic        to_hit;

`ifdef SLAVE_PORT_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] to_cnt;

  // Counter is held at zero outside REQ, so it is already clear on REQ entry.
  always_ff @(posedge clk) begin
    if (rst)
      to_cnt <= '0;
    else if (state == REQ)
      to_cnt <= to_cnt + 1'b1;
    else
      to_cnt <= '0;
  end

  assign to_hit = (state == REQ) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    if (gnt) begin
      gnt_req   = bus.master_1_req;
      gnt_cmd   = bus.master_1_cmd;
      gnt_addr  = bus.master_1_addr;
      gnt_wdata = bus.master_1_wdata;
    end else begin
      gnt_req   = bus.master_0_req;
      gnt_cmd   = bus.master_0_cmd;
      gnt_addr  = bus.master_0_addr;
      gnt_wdata = bus.master_0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    last_gnt_nxt = last_gnt;
    gnt_ack      = 1'b0;
    gnt_rdata    = '0;
    err          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.master_0_req || bus.master_1_req) begin
          gnt_nxt      = (bus.master_0_req && bus.master_1_req) ? ~last_gnt : bus.master_1_req;
          last_gnt_nxt = gnt_nxt;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        // A real slave ack outranks both a dropped request and the timeout.
        if (bus.slave_ack) begin
          gnt_ack   = 1'b1;
          state_nxt = gnt_cmd ? IDLE : RDATA;
        end else if (!gnt_req) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          gnt_ack   = 1'b1;
          err       = 1'b1;
          gnt_rdata = gnt_cmd ? 32'h0 : 32'hDEAD_BEEF;
          state_nxt = IDLE;
        end
      end
      RDATA: begin
        gnt_rdata = bus.slave_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while rst is high, so an aborted transfer never acks.
  always_comb begin
    bus.master_0_ack   = 1'b0;
    bus.master_1_ack   = 1'b0;
    bus.master_0_rdata = '0;
    bus.master_1_rdata = '0;
    bus.slave_req      = 1'b0;
    bus.slave_cmd      = 1'b0;
    bus.slave_addr     = '0;
    bus.slave_wdata    = '0;
    bus.slave_err      = 1'b0;
    if (!rst) begin
      if (gnt) begin
        bus.master_1_ack   = gnt_ack;
        bus.master_1_rdata = gnt_rdata;
      end else begin
        bus.master_0_ack   = gnt_ack;
        bus.master_0_rdata = gnt_rdata;
      end
      if (state == REQ) begin
        bus.slave_req   = 1'b1;
        bus.slave_cmd   = gnt_cmd;
        bus.slave_addr  = gnt_addr;
        bus.slave_wdata = gnt_wdata;
      end
      bus.slave_err = err;
    end
  end

endmodule

// File: tb/tb_slave_port_sched.sv
// Randomized scoreboard bench for slave_port_sched: a transaction timeline model
// predicts every cycle's outputs; a separate monitor pops and compares them.
module tb_slave_port_sched;
  localparam int unsigned TO   = 16;
  localparam int          NCYC = 3000;
  localparam int          NRST = 3;

  typedef struct {
    bit        cmd;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        delay;
    int        drop;
  } txn_t;

  typedef struct packed {
    logic        m0_ack;
    logic        m1_ack;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic        s_req;
    logic        s_cmd;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_err;
  } out_t;

  typedef struct {
    int   cyc;
    out_t o;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slave_port_sched_if bus();

  slave_port_sched #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  txn_t tx[2];
  bit   busy[2];
  int   gap[2];
  txn_t cur_tx;
  int   cur = -1;
  int   t0 = 0;
  int   next_idle = 0;
  bit   last = 1'b1;
  int   n_mid_rst = 0;

  // REQ-cycle offset at which the transaction ends with an ack (real or timeout).
  function automatic int end_k(input txn_t t);
    int e;
    e = t.delay;
`ifdef SLAVE_PORT_TIMEOUT_EN
    if (e > int'(TO) - 1) e = int'(TO) - 1;
`endif
    return e;
  endfunction

  function automatic txn_t new_txn();
    txn_t t;
    int   lim;
    t.cmd   = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.delay = $urandom_range(0, 5);
`ifdef SLAVE_PORT_TIMEOUT_EN
    if ($urandom_range(0, 7) == 0) t.delay = 1000;
`endif
    t.drop = -1;
    lim = end_k(t);
    if (lim >= 2 && $urandom_range(0, 7) == 0) t.drop = $urandom_range(1, lim - 1);
    return t;
  endfunction

  task automatic driver();
    out_t      e;
    bit        r;
    bit        req_d[2];
    bit        s_ack;
    bit [31:0] s_rd;
    int        k;
    exp_t      x;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      e     = '0;
      s_ack = 1'b0;
      s_rd  = $urandom;
      r     = (c < NRST);

      if (!r && cur >= 0 && c >= t0 && busy[0] && busy[1] && n_mid_rst < 6 &&
          $urandom_range(0, 19) == 0) begin
        k = c - t0;
        if (k < end_k(cur_tx) && (cur_tx.drop < 0 || k < cur_tx.drop)) r = 1'b1;
      end

      for (int m = 0; m < 2; m++) begin
        if (!busy[m]) begin
          if (gap[m] > 0) gap[m]--;
          else if (c >= NRST) begin
            tx[m]   = new_txn();
            busy[m] = 1'b1;
          end
        end
        req_d[m] = busy[m];
        if (cur == m && c >= t0 && cur_tx.drop >= 0 && c - t0 == cur_tx.drop) req_d[m] = 1'b0;
      end

      if (r) begin
        cur       = -1;
        next_idle = c + 1;
        last      = 1'b1;
        if (c >= NRST) n_mid_rst++;
      end else if (cur < 0) begin
        if (c >= next_idle && (req_d[0] || req_d[1])) begin
          if (req_d[0] && req_d[1]) cur = last ? 0 : 1;
          else cur = req_d[0] ? 0 : 1;
          last   = (cur == 1);
          cur_tx = tx[cur];
          t0     = c + 1;
        end
      end else if (c >= t0) begin
        k = c - t0;
        if (k == end_k(cur_tx) + 1) begin
          s_rd = cur_tx.rdata;
          if (cur == 0) e.m0_rdata = cur_tx.rdata; else e.m1_rdata = cur_tx.rdata;
          cur       = -1;
          next_idle = c + 1;
        end else begin
          e.s_req   = 1'b1;
          e.s_cmd   = cur_tx.cmd;
          e.s_addr  = cur_tx.addr;
          e.s_wdata = cur_tx.wdata;
          if (k == end_k(cur_tx)) begin
            if (cur == 0) e.m0_ack = 1'b1; else e.m1_ack = 1'b1;
            busy[cur] = 1'b0;
            gap[cur]  = $urandom_range(0, 3);
            if (k == cur_tx.delay) begin
              s_ack = 1'b1;
              if (cur_tx.cmd) begin
                cur       = -1;
                next_idle = c + 1;
              end
            end else begin
              e.s_err = 1'b1;
              if (!cur_tx.cmd) begin
                if (cur == 0) e.m0_rdata = 32'hDEAD_BEEF; else e.m1_rdata = 32'hDEAD_BEEF;
              end
              cur       = -1;
              next_idle = c + 1;
            end
          end else if (k == cur_tx.drop) begin
            busy[cur] = 1'b0;
            gap[cur]  = $urandom_range(0, 3);
            cur       = -1;
            next_idle = c + 1;
          end
        end
      end

      rst                = r;
      bus.master_0_req   = req_d[0];
      bus.master_0_cmd   = tx[0].cmd;
      bus.master_0_addr  = tx[0].addr;
      bus.master_0_wdata = tx[0].wdata;
      bus.master_1_req   = req_d[1];
      bus.master_1_cmd   = tx[1].cmd;
      bus.master_1_addr  = tx[1].addr;
      bus.master_1_wdata = tx[1].wdata;
      bus.slave_ack      = s_ack;
      bus.slave_rdata    = s_rd;
      x.cyc = c;
      x.o   = e;
      exp_q.push_back(x);
    end
  endtask

  task automatic monitor();
    out_t got;
    exp_t x;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      #2;
      got.m0_ack   = bus.master_0_ack;
      got.m1_ack   = bus.master_1_ack;
      got.m0_rdata = bus.master_0_rdata;
      got.m1_rdata = bus.master_1_rdata;
      got.s_req    = bus.slave_req;
      got.s_cmd    = bus.slave_cmd;
      got.s_addr   = bus.slave_addr;
      got.s_wdata  = bus.slave_wdata;
      got.s_err    = bus.slave_err;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow at sample %0d: got %h, no expected entry", i, got);
      end else begin
        x = exp_q.pop_front();
        if (got !== x.o) begin
          n_fail++;
          $display("FAIL outputs cyc %0d: got ack=%b%b rd0=%h rd1=%h sreq=%b cmd=%b addr=%h wd=%h err=%b, expected ack=%b%b rd0=%h rd1=%h sreq=%b cmd=%b addr=%h wd=%h err=%b",
                   x.cyc, got.m0_ack, got.m1_ack, got.m0_rdata, got.m1_rdata, got.s_req,
                   got.s_cmd, got.s_addr, got.s_wdata, got.s_err,
                   x.o.m0_ack, x.o.m1_ack, x.o.m0_rdata, x.o.m1_rdata, x.o.s_req,
                   x.o.s_cmd, x.o.s_addr, x.o.s_wdata, x.o.s_err);
        end
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.master_0_req   = 1'b0;
    bus.master_1_req   = 1'b0;
    bus.master_0_cmd   = 1'b0;
    bus.master_1_cmd   = 1'b0;
    bus.master_0_addr  = '0;
    bus.master_1_addr  = '0;
    bus.master_0_wdata = '0;
    bus.master_1_wdata = '0;
    bus.slave_ack      = 1'b0;
    bus.slave_rdata    = '0;
    for (int m = 0; m < 2; m++) begin
      busy[m]  = 1'b0;
      gap[m]   = 0;
      tx[m]    = '{default: 0};
    end
    fork
      driver();
      monitor();
    join
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/slave_port_sched.md
SLAVE_PORT_SCHED -- requirements
Module: slave_port_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: cycles in REQ without s_ack before abort (timeout build only).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 master_0_req / master_1_req  in  1 each  request; held high until the master sees its ack.
REQ-005 master_0_cmd / master_1_cmd  in  1 each  0 = read, 1 = write; stable while req is high.
REQ-006 master_0_addr / master_1_addr, master_0_wdata / master_1_wdata  in  32 each  stable while req is high.
REQ-007 master_0_ack / master_1_ack  out  1 each  transaction accepted or aborted.
REQ-008 master_0_rdata / master_1_rdata  out  32 each  read data to the master.
REQ-009 slave_req  out  1  request to the slave.
REQ-010 slave_cmd  out  1; slave_addr, slave_wdata  out  32 each  muxed from the granted master.
REQ-011 slave_ack  in  1; slave_rdata  in  32  slave_rdata is valid the cycle after slave_ack for reads.
REQ-012 slave_err  out  1  timeout abort pulse; tied 0 when the timeout feature is not compiled in.

Function
REQ-013 FSM states SHALL be IDLE, REQ and RDATA.
REQ-014 IDLE: if any master_N_req is high, register the grant (gnt) and go to REQ next cycle; otherwise stay in IDLE.
REQ-015 Round-robin: if both masters request, the master other than last_gnt SHALL win; if one requests, it wins; update last_gnt on grant.
REQ-016 REQ: slave_req = 1; slave_cmd, slave_addr and slave_wdata SHALL come combinationally from master gnt.
REQ-017 REQ with slave_ack = 1: master_gnt_ack = slave_ack in the same cycle; write goes to IDLE, read goes to RDATA.
REQ-018 RDATA (one cycle): master_gnt_rdata = slave_rdata, then go to IDLE.
REQ-019 The non-granted master's ack SHALL be 0 and its rdata 0 at all times; the granted master's rdata SHALL be 0 outside RDATA (except REQ-027).
REQ-020 Outside REQ: slave_req = 0, slave_cmd = 0, slave_addr = 0, slave_wdata = 0.
REQ-021 Latency: req sampled at cycle 0 gives slave_req at cycle 1; the earliest ack is at cycle 1; read data reaches the master at ack cycle + 1.
REQ-022 After each transaction the FSM passes through one IDLE cycle before the next grant.
REQ-023 If master gnt drops req in REQ without slave_ack (protocol violation), go to IDLE next cycle with no ack to that master.
REQ-024 Requests arriving during REQ/RDATA wait; they are never lost or acked early.

Reset
REQ-025 rst SHALL force, on the next edge and from any state (including mid-transaction): state = IDLE, last_gnt = 1 (master 0 wins first tie), timeout counter = 0.
REQ-026 During and after reset: all outputs = 0, with no ack pulse for an aborted transaction.

Configuration
REQ-027 With SLAVE_PORT_TIMEOUT_EN defined: a counter runs in REQ and clears on entry to REQ. When it reaches TIMEOUT_CYCLES-1 without slave_ack, in that cycle: master_gnt_ack = 1, slave_err = 1, master_gnt_rdata = 32'hDEADBEEF if the command is a read (0 for writes). The FSM then goes to IDLE; slave_ack in that same cycle takes priority (normal completion, no err).
REQ-028 Without SLAVE_PORT_TIMEOUT_EN: no counter, slave_err = 0, and REQ waits indefinitely for slave_ack.

Verification
REQ-029 Master 0 writes addr 0x0000_0010, wdata 0xA5A5_A5A5; slave acks in its first REQ cycle -> slave_req at cycle 1 with those values, master_0_ack at cycle 1, IDLE at cycle 2.
REQ-030 Master 1 reads; slave acks at cycle 3 and drives slave_rdata 0x1234_5678 at cycle 4 -> master_1_ack at cycle 3, master_1_rdata = 0x1234_5678 at cycle 4 only, master_0_rdata = 0 throughout.
REQ-031 Both masters hold req continuously after reset, with immediate slave acks -> grants alternate M0, M1, M0, M1, and each transaction takes 2 cycles (write) or 3 cycles (read).
REQ-032 rst asserted while in REQ with slave_ack = 0 -> next cycle state = IDLE, slave_req = 0, no master ack; the first tie after reset goes to M0.
REQ-033 (timeout build) Read with slave_ack stuck low, TIMEOUT_CYCLES = 16 -> at REQ cycle 16: master_ack = 1, slave_err = 1, rdata = 0xDEADBEEF; the next cycle is IDLE.
REQ-034 Master 0 drops req at its second REQ cycle with no slave_ack -> no master_0_ack, IDLE next cycle, and a pending master 1 request is granted after that.
